io_interp_gray_stepper: RTL and testbench

Generates the 3-bit gray-coded phase select that drives the interpolator mux-select latch, which feeds the 8-to-1 phase multiplexer. It accepts a binary target phase index through a valid/ready handshake. It then walks the select toward the target one phase step at a time, taking the shortest direction around the 8-phase ring. Each step changes exactly one select bit and is followed by a programmable settle interval, so the downstream latch and mux never see a multi-bit transition.

---
 rtl/io_interp_gray_stepper_if.sv | 26 ++
 rtl/io_interp_gray_stepper.sv | 104 ++++++++++
 tb/tb_io_interp_gray_stepper.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_interp_gray_stepper_if.sv
// Handshake and phase-select bundle between a target requester and the gray stepper.
// Latency: none; this is wiring only.
// Backpressure: tgt_ready is driven by the stepper and stays low while a move is in flight.
// Ports (slave view): tgt_valid/tgt_code/hold in; tgt_ready, mux_sel_out, pos_bin,
//   busy, step_dn, done out.
interface io_interp_gray_stepper_if;
  logic       tgt_valid;
  logic [2:0] tgt_code;
  logic       tgt_ready;
  logic       hold;
  logic [2:0] mux_sel_out;
  logic [2:0] pos_bin;
  logic       busy;
  logic       step_dn;
  logic       done;

  modport master (
    output tgt_valid, tgt_code, hold,
    input  tgt_ready, mux_sel_out, pos_bin, busy, step_dn, done
  );

  modport slave (
    input  tgt_valid, tgt_code, hold,
    output tgt_ready, mux_sel_out, pos_bin, busy, step_dn, done
  );
endinterface

// File: rtl/io_interp_gray_stepper.sv
// Walks a 3-bit gray phase select toward a requested phase, one bit flip per step.
// Latency: first step one edge after accept, then one step per SETTLE_CYC+1 edges; done one edge after settle.
// Backpressure: tgt_ready is high only in IDLE; requests during a move are ignored.
// Ports: clk, l_reset (sync, active-high); bus (slave modport) carries the target
//   handshake, hold, and the registered select/position/status outputs.
module io_interp_gray_stepper #(
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic                          clk,
  input  logic                          l_reset,
  io_interp_gray_stepper_if.slave       bus
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYC);

  typedef enum logic {IDLE, MOVE} state_t;

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] tgt_q, tgt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dn_q, dn_d;
  logic       done_q, done_d;

  logic [2:0] diff;
  logic       go_dn;
  logic [2:0] pos_nxt;

  function automatic logic [2:0] gray3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  // Distance around the ring; 5..7 is shorter going down, the 4 tie goes up.
  assign diff  = tgt_q - pos_q;
  assign go_dn = diff[2] & (diff[1] | diff[0]);

  always_ff @(posedge clk) begin
    if (l_reset) begin
      state_q <= IDLE;
      pos_q   <= 3'd0;
      sel_q   <= 3'd0;
      tgt_q   <= 3'd0;
      cnt_q   <= 4'd0;
      dn_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      dn_q    <= dn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    dn_d    = dn_q;
    done_d  = 1'b0;
    pos_nxt = go_dn ? (pos_q - 3'd1) : (pos_q + 3'd1);
    case (state_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d   = bus.tgt_code;
          cnt_d   = 4'd0;
          state_d = MOVE;
        end
      end
      MOVE: begin
        // hold freezes everything, including the settle countdown.
        if (!bus.hold) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (pos_q != tgt_q) begin
            pos_d = pos_nxt;
            // Select register is loaded from the next position so it tracks
            // gray(pos_bin) edge-for-edge without a combinational port path.
            sel_d = gray3(pos_nxt);
            dn_d  = go_dn;
            cnt_d = SETTLE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tgt_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q == MOVE);
  assign bus.mux_sel_out = sel_q;
  assign bus.pos_bin     = pos_q;
  assign bus.step_dn     = dn_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_io_interp_gray_stepper.sv
// Directed bench for io_interp_gray_stepper with SETTLE_CYC=3.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
// A monitor checks every non-reset select change for single-bit flips and spacing.
module tb_io_interp_gray_stepper;

  localparam int S = 3;

  logic clk;
  logic l_reset;
  int   n_chk;
  int   n_err;

  io_interp_gray_stepper_if bus_if ();

  io_interp_gray_stepper #(.SETTLE_CYC(S)) dut (
    .clk    (clk),
    .l_reset(l_reset),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one target; returns 1ns after the accept edge (E0).
  task automatic accept(input logic [2:0] code);
    chk("ready_before_accept", int'(bus_if.tgt_ready), 1);
    bus_if.tgt_valid = 1'b1;
    bus_if.tgt_code  = code;
    adv(1);
    bus_if.tgt_valid = 1'b0;
  endtask

  // Select-change monitor.
  logic [2:0] prev_sel;
  logic       rst_edge;
  logic       have_last;
  int         cyc;
  int         last_cyc;

  initial begin
    prev_sel  = 3'd0;
    have_last = 1'b0;
    cyc       = 0;
    last_cyc  = 0;
  end

  always begin
    @(posedge clk);
    rst_edge = l_reset;
    #2;
    cyc++;
    if (rst_edge) begin
      have_last = 1'b0;
    end else if (bus_if.mux_sel_out !== prev_sel) begin
      chk("onebit", $countones(bus_if.mux_sel_out ^ prev_sel), 1);
      if (have_last) chk("settle_gap", int'((cyc - last_cyc) >= S + 1), 1);
      have_last = 1'b1;
      last_cyc  = cyc;
    end
    prev_sel = bus_if.mux_sel_out;
  end

  initial begin
    n_chk            = 0;
    n_err            = 0;
    clk              = 1'b0;
    l_reset          = 1'b1;
    bus_if.tgt_valid = 1'b0;
    bus_if.tgt_code  = 3'd0;
    bus_if.hold      = 1'b0;

    // Reset
    adv(2);
    chk("rst_sel",   int'(bus_if.mux_sel_out), 0);
    chk("rst_pos",   int'(bus_if.pos_bin), 0);
    chk("rst_ready", int'(bus_if.tgt_ready), 1);
    chk("rst_busy",  int'(bus_if.busy), 0);
    chk("rst_done",  int'(bus_if.done), 0);
    chk("rst_dn",    int'(bus_if.step_dn), 0);
    l_reset = 1'b0;
    adv(1);

    // 0 -> 2 up, steps at E1/E5, done at E9
    accept(3'd2);
    chk("a_busy",  int'(bus_if.busy), 1);
    chk("a_ready", int'(bus_if.tgt_ready), 0);
    adv(1);
    chk("a_e1_sel", int'(bus_if.mux_sel_out), 3'b001);
    chk("a_e1_pos", int'(bus_if.pos_bin), 1);
    chk("a_e1_dn",  int'(bus_if.step_dn), 0);
    adv(3);
    chk("a_e4_sel", int'(bus_if.mux_sel_out), 3'b001);
    adv(1);
    chk("a_e5_sel", int'(bus_if.mux_sel_out), 3'b011);
    chk("a_e5_pos", int'(bus_if.pos_bin), 2);
    adv(3);
    chk("a_e8_done", int'(bus_if.done), 0);
    chk("a_e8_busy", int'(bus_if.busy), 1);
    adv(1);
    chk("a_e9_done",  int'(bus_if.done), 1);
    chk("a_e9_ready", int'(bus_if.tgt_ready), 1);
    chk("a_e9_busy",  int'(bus_if.busy), 0);
    adv(1);
    chk("a_e10_done", int'(bus_if.done), 0);

    // 2 -> 1 (d=7, down), done at E5, then back-to-back accept
    accept(3'd1);
    adv(5);
    chk("b_done", int'(bus_if.done), 1);
    chk("b_pos",  int'(bus_if.pos_bin), 1);
    chk("b_dn",   int'(bus_if.step_dn), 1);

    // 1 -> 6 (d=5, down): 0, 7, 6
    accept(3'd6);
    chk("c_done_drop", int'(bus_if.done), 0);
    adv(1);
    chk("c_e1_pos", int'(bus_if.pos_bin), 0);
    chk("c_e1_sel", int'(bus_if.mux_sel_out), 3'b000);
    chk("c_e1_dn",  int'(bus_if.step_dn), 1);
    adv(4);
    chk("c_e5_pos", int'(bus_if.pos_bin), 7);
    chk("c_e5_sel", int'(bus_if.mux_sel_out), 3'b100);
    adv(4);
    chk("c_e9_pos", int'(bus_if.pos_bin), 6);
    chk("c_e9_sel", int'(bus_if.mux_sel_out), 3'b101);
    adv(3);
    chk("c_e12_done", int'(bus_if.done), 0);
    adv(1);
    chk("c_e13_done", int'(bus_if.done), 1);
    adv(1);

    // 6 -> 0 (d=2, up, wraps 7->0)
    accept(3'd0);
    adv(5);
    chk("d_e5_pos", int'(bus_if.pos_bin), 0);
    chk("d_e5_sel", int'(bus_if.mux_sel_out), 3'b000);
    chk("d_e5_dn",  int'(bus_if.step_dn), 0);
    adv(4);
    chk("d_e9_done", int'(bus_if.done), 1);
    adv(1);

    // 0 -> 4 tie goes up, four steps, done at E17
    accept(3'd4);
    adv(1);
    chk("e_e1_pos", int'(bus_if.pos_bin), 1);
    adv(8);
    chk("e_e9_pos", int'(bus_if.pos_bin), 3);
    adv(4);
    chk("e_e13_pos", int'(bus_if.pos_bin), 4);
    chk("e_e13_sel", int'(bus_if.mux_sel_out), 3'b110);
    chk("e_e13_dn",  int'(bus_if.step_dn), 0);
    adv(4);
    chk("e_e17_done", int'(bus_if.done), 1);
    adv(1);

    // 4 -> 4 zero steps, done at E1
    accept(3'd4);
    chk("f_busy", int'(bus_if.busy), 1);
    adv(1);
    chk("f_e1_done", int'(bus_if.done), 1);
    chk("f_e1_pos",  int'(bus_if.pos_bin), 4);
    adv(1);

    // 4 -> 0 (tie, up through 5,6,7,0), done at E17
    accept(3'd0);
    adv(13);
    chk("g_e13_sel", int'(bus_if.mux_sel_out), 3'b000);
    adv(4);
    chk("g_e17_done", int'(bus_if.done), 1);
    adv(1);

    // 0 -> 3 with hold over edges E3..E7 and a code-7 request while busy
    accept(3'd3);
    adv(2);
    chk("h_e2_pos", int'(bus_if.pos_bin), 1);
    bus_if.hold      = 1'b1;
    bus_if.tgt_valid = 1'b1;
    bus_if.tgt_code  = 3'd7;
    adv(2);
    bus_if.tgt_valid = 1'b0;
    adv(3);
    bus_if.hold = 1'b0;
    adv(2);
    chk("h_e9_pos", int'(bus_if.pos_bin), 1);
    adv(1);
    chk("h_e10_pos", int'(bus_if.pos_bin), 2);
    adv(4);
    chk("h_e14_pos", int'(bus_if.pos_bin), 3);
    chk("h_e14_sel", int'(bus_if.mux_sel_out), 3'b010);
    adv(3);
    chk("h_e17_done", int'(bus_if.done), 0);
    chk("h_e17_busy", int'(bus_if.busy), 1);
    adv(1);
    chk("h_e18_done", int'(bus_if.done), 1);
    chk("h_e18_pos",  int'(bus_if.pos_bin), 3);
    adv(3);
    chk("h_final_pos",   int'(bus_if.pos_bin), 3);
    chk("h_final_ready", int'(bus_if.tgt_ready), 1);

    // 3 -> 0 (d=5, down), then 0 -> 5 with reset at step 2 (E5)
    accept(3'd0);
    adv(13);
    chk("i_e13_done", int'(bus_if.done), 1);
    chk("i_e13_pos",  int'(bus_if.pos_bin), 0);
    adv(1);
    accept(3'd5);
    adv(1);
    chk("j_e1_pos", int'(bus_if.pos_bin), 7);
    adv(3);
    l_reset = 1'b1;
    adv(1);
    l_reset = 1'b0;
    chk("j_rst_pos",   int'(bus_if.pos_bin), 0);
    chk("j_rst_sel",   int'(bus_if.mux_sel_out), 0);
    chk("j_rst_busy",  int'(bus_if.busy), 0);
    chk("j_rst_ready", int'(bus_if.tgt_ready), 1);
    chk("j_rst_done",  int'(bus_if.done), 0);
    adv(1);
    chk("j_post_done", int'(bus_if.done), 0);
    chk("j_post_pos",  int'(bus_if.pos_bin), 0);
    adv(4);
    chk("j_late_done", int'(bus_if.done), 0);
    chk("j_late_busy", int'(bus_if.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
